// File: rtl/bus_arbiter_rr_if.sv
// ------------------------------------------------------------------
// bus_arbiter_rr_if : request/grant bundle between sources and arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface bus_arbiter_rr_if #(
  parameter int NUM_INPUT = 8,
  parameter int SEL_BIT   = 3
);
  logic [NUM_INPUT-1:0] req_in;
  logic [NUM_INPUT-1:0] grant_out;
  logic [SEL_BIT-1:0]   sel_out;
  logic                 valid_out;

  modport master (
    input  req_in,
    output grant_out,
    output sel_out,
    output valid_out
  );

  modport slave (
    output req_in,
    input  grant_out,
    input  sel_out,
    input  valid_out
  );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
// ------------------------------------------------------------------
// bus_arbiter_rr : round-robin arbiter with bounded hold and a one-cycle dead gap
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module bus_arbiter_rr #(
  parameter int NUM_INPUT = 8,
  parameter int SEL_BIT   = 3,
  parameter int MAX_HOLD  = 4
) (
  input  wire              clk,
  input  wire              rst_n,
  bus_arbiter_rr_if.master bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NUM_INPUT-1:0] grant_q, grant_d;
  logic [SEL_BIT-1:0]   sel_q, sel_d;
  logic                 valid_q, valid_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [SEL_BIT-1:0]   last_idx_q, last_idx_d;

  logic                 any_req;
  logic                 others_req;
  logic                 owner_req;
  logic                 hold_full;
  logic                 release_now;
  logic                 pick_found;
  logic [SEL_BIT-1:0]   pick_idx;
  int                   cand;

  assign any_req     = |bus.req_in;
  assign others_req  = |(bus.req_in & ~grant_q);
  assign owner_req   = bus.req_in[sel_q];
  assign hold_full   = (hold_cnt_q == HOLD_W'(MAX_HOLD));
  assign release_now = !owner_req || (hold_full && others_req);

  // Search starts just past the last owner so it only wins again when alone.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < NUM_INPUT; k++) begin
      cand = (int'(last_idx_q) + 1 + k) % NUM_INPUT;
      if (!pick_found && bus.req_in[cand]) begin
        pick_found = 1'b1;
        pick_idx   = SEL_BIT'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      hold_cnt_q <= '0;
      last_idx_q <= SEL_BIT'(NUM_INPUT - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      hold_cnt_q <= hold_cnt_d;
      last_idx_q <= last_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_SWITCH: state_d = any_req ? ST_GRANT : ST_IDLE;
      ST_GRANT:           state_d = release_now ? ST_SWITCH : ST_GRANT;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    hold_cnt_d = hold_cnt_q;
    last_idx_d = last_idx_q;
    case (state_q)
      ST_IDLE, ST_SWITCH: begin
        if (pick_found) begin
          grant_d    = NUM_INPUT'(1) << pick_idx;
          sel_d      = pick_idx;
          valid_d    = 1'b1;
          hold_cnt_d = HOLD_W'(1);
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          // sel stays on the old owner so the mux select is stable in the gap
          grant_d    = '0;
          valid_d    = 1'b0;
          last_idx_d = sel_q;
        end else if (!hold_full) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.grant_out = grant_q;
  assign bus.sel_out   = sel_q;
  assign bus.valid_out = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
// ------------------------------------------------------------------
// tb_bus_arbiter_rr : directed scoreboard bench for bus_arbiter_rr
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_bus_arbiter_rr;

  localparam int NUM_INPUT = 8;
  localparam int SEL_BIT   = 3;
  localparam int MAX_HOLD  = 4;

  typedef struct {
    string      name;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  event smp_ev;

  bus_arbiter_rr_if #(.NUM_INPUT(NUM_INPUT), .SEL_BIT(SEL_BIT)) bus ();

  bus_arbiter_rr #(
    .NUM_INPUT(NUM_INPUT),
    .SEL_BIT  (SEL_BIT),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string nm, input logic [7:0] g, input logic [2:0] s, input logic v);
    exp_t e;
    e.name  = nm;
    e.grant = g;
    e.sel   = s;
    e.valid = v;
    sb.push_back(e);
  endtask

  // Drive req for the coming edge and queue the outputs expected after it.
  task automatic step(input string nm, input logic [7:0] r,
                      input logic [7:0] g, input logic [2:0] s, input logic v);
    @(negedge clk);
    bus.req_in = r;
    push_exp(nm, g, s, v);
  endtask

  // Monitor: outputs are examined after every edge or on an asynchronous sample request.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or smp_ev);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.grant_out !== e.grant) begin
          errors++;
          $display("FAIL %s grant: got %h want %h", e.name, bus.grant_out, e.grant);
        end
        checks++;
        if (bus.sel_out !== e.sel) begin
          errors++;
          $display("FAIL %s sel: got %0d want %0d", e.name, bus.sel_out, e.sel);
        end
        checks++;
        if (bus.valid_out !== e.valid) begin
          errors++;
          $display("FAIL %s valid: got %b want %b", e.name, bus.valid_out, e.valid);
        end
        checks++;
        if (bus.valid_out !== (|bus.grant_out) || !$onehot0(bus.grant_out)) begin
          errors++;
          $display("FAIL %s invariant: grant %h valid %b", e.name, bus.grant_out, bus.valid_out);
        end
        if (bus.valid_out === 1'b1) begin
          checks++;
          if (bus.grant_out[bus.sel_out] !== 1'b1) begin
            errors++;
            $display("FAIL %s sel_vs_grant: sel %0d grant %h", e.name, bus.sel_out, bus.grant_out);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] oh;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.req_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single source 2
    step("single_grant",   8'h04, 8'h04, 3'd2, 1'b1);
    step("single_release", 8'h00, 8'h00, 3'd2, 1'b0);
    step("single_idle",    8'h00, 8'h00, 3'd2, 1'b0);
    step("single_idle2",   8'h00, 8'h00, 3'd2, 1'b0);

    // Asynchronous reset between edges: sel must clear from 2 without an edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp("async_reset", 8'h00, 3'd0, 1'b0);
    -> smp_ev;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("reset_idle", 8'h00, 8'h00, 3'd0, 1'b0);

    // Full load: every owner holds MAX_HOLD cycles, then a dead cycle
    for (int n = 0; n < 9; n++) begin
      oh = 8'h01 << (n % 8);
      for (int c = 0; c < MAX_HOLD; c++)
        step("full_hold", 8'hFF, oh, 3'(n % 8), 1'b1);
      step("full_gap", 8'hFF, 8'h00, 3'(n % 8), 1'b0);
    end
    step("full_idle", 8'h00, 8'h00, 3'd0, 1'b0);

    // Lone requester keeps the bus; saturated hold releases at once when 0 joins
    for (int i = 0; i < 10; i++) step("lone_hold", 8'h80, 8'h80, 3'd7, 1'b1);
    step("lone_sat_release", 8'h81, 8'h00, 3'd7, 1'b0);
    step("lone_next",        8'h81, 8'h01, 3'd0, 1'b1);
    step("lone_drop",        8'h00, 8'h00, 3'd0, 1'b0);
    step("lone_idle",        8'h00, 8'h00, 3'd0, 1'b0);

    // Wrap fairness between sources 3 and 0
    step("wrap_grant3", 8'h08, 8'h08, 3'd3, 1'b1);
    for (int i = 0; i < 3; i++) step("wrap_hold3", 8'h09, 8'h08, 3'd3, 1'b1);
    step("wrap_rel3", 8'h09, 8'h00, 3'd3, 1'b0);
    step("wrap_grant0", 8'h09, 8'h01, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) step("wrap_hold0", 8'h09, 8'h01, 3'd0, 1'b1);
    step("wrap_rel0",    8'h09, 8'h00, 3'd0, 1'b0);
    step("wrap_regrant3", 8'h09, 8'h08, 3'd3, 1'b1);
    step("wrap_drop3",   8'h00, 8'h00, 3'd3, 1'b0);
    step("wrap_idle",    8'h00, 8'h00, 3'd3, 1'b0);

    // Reset while source 5 owns the bus; pointer returns to its reset value
    step("rst5_grant", 8'h20, 8'h20, 3'd5, 1'b1);
    step("rst5_hold",  8'h20, 8'h20, 3'd5, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.req_in = 8'h21;
    #1;
    push_exp("rst5_async", 8'h00, 3'd0, 1'b0);
    -> smp_ev;
    @(negedge clk);
    rst_n = 1'b1;
    push_exp("rst5_first0", 8'h01, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) step("rst5_hold0", 8'h21, 8'h01, 3'd0, 1'b1);
    step("rst5_rel0",  8'h21, 8'h00, 3'd0, 1'b0);
    step("rst5_then5", 8'h21, 8'h20, 3'd5, 1'b1);
    step("rst5_drop",  8'h00, 8'h00, 3'd5, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
